cpu7_exu_byp_scb: RTL and testbench
===================================

# cpu7_exu_byp_scb

Parametrised operand bypass and load scoreboard for the cpu7 execution unit. It sits between the D-stage register-file read ports and the E-stage operand latches. It forwards in-flight results from a configurable number of bypass channels plus the LSU load-return channel. It tracks outstanding long-latency load destinations and raises a D-stage stall for RAW and WAW hazards and for load-queue overflow.

## Interface
Parameters:
- GRLEN, 32, datapath width
- RW, 5, register index width; NREG = 2**RW
- NBYP, 2, bypass channels; channel 0 is youngest and has highest priority
- LD_DEPTH, 4, maximum outstanding loads, at least 1

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid_d  in  1  D-stage instruction present
- rs1_d, rs2_d  in  RW  source indices
- rd_d  in  RW  destination index
- rd_wen_d  in  1  instruction writes rd
- is_load_d  in  1  instruction is a long-latency load
- irf_rs1_data_d, irf_rs2_data_d  in  GRLEN  register-file read data
- stall_e  in  1  downstream hold; no issue is accepted
- byp_valid  in  NBYP  bypass channel valid
- byp_rd  in  NBYP*RW  packed channel destinations, channel i at [i*RW +: RW]
- byp_data  in  NBYP*GRLEN  packed channel data
- ld_ret_valid  in  1  load data returning this cycle
- ld_ret_rd  in  RW  returning destination
- ld_ret_data  in  GRLEN  returning data
- rs1_fwd_d, rs2_fwd_d  out  GRLEN  forwarded operands (combinational)
- stall_d  out  1  hazard stall (combinational)
- ld_pend_cnt  out  clog2(LD_DEPTH+1)  outstanding loads (registered, reset 0)
- scb_err  out  1  sticky protocol error (registered, reset 0)

## Operation
- State:
  - pend[NREG-1:0]; reset all 0; pend[0] is never set.
  - ld_pend_cnt.
  - scb_err.
- ret_hit = ld_ret_valid & ld_ret_rd != 0.
- ready(r):
  - true when r == 0;
  - otherwise true when !pend[r], or when ret_hit & ld_ret_rd == r.
- Operand forwarding (per source, index s):
  - s == 0: result is 0.
  - Otherwise take the lowest-numbered i with byp_valid[i] & byp_rd[i] == s.
  - Failing that, take ld_ret_data when ret_hit & ld_ret_rd == s.
  - Failing that, take the irf data.
  - Bypass channels whose rd is 0 are ignored.
- stall_d is asserted when issue_valid_d and any of the following holds:
  - RAW: !ready(rs1_d) or !ready(rs2_d).
  - WAW: rd_wen_d & !ready(rd_d). Any writer stalls, not only loads.
  - Load-queue full: is_load_d & rd_wen_d & rd_d != 0 & ld_pend_cnt == LD_DEPTH & !ret_hit.
- accept = issue_valid_d & !stall_d & !stall_e.
- set = accept & is_load_d & rd_wen_d & rd_d != 0.
- Per-register update: clear pend[ld_ret_rd] on ret_hit, then set pend[rd_d] on set. When both name the same register, pend stays 1.
- Counter update: ld_pend_cnt += set − (ret_hit & pend[ld_ret_rd]). Simultaneous increment and decrement leaves it unchanged. It never wraps.
- Return to a non-pending register: scb_err is set, pend and the counter are unchanged, and data is still forwarded.
- Loads without rd_wen, or with rd 0, are not tracked.

## Timing
- Forwarding and stall_d are combinational from D-stage inputs and current state. There are zero cycles of bypass latency.
- pend, ld_pend_cnt and scb_err update on the rising clk edge following the event.
- A load accepted in cycle N makes its rd not-ready from cycle N+1.
- A dependent instruction stalls until the cycle of ld_ret_valid, and issues in that same cycle using ld_ret_data.
- reset asserted mid-operation clears pend, ld_pend_cnt and scb_err immediately. Load returns arriving after reset set scb_err.
- stall_e does not affect stall_d. It only blocks state updates through accept.

## Structure
- GRLEN comes from common.vh.
- Add the LD_DEPTH default and counter-width macro to common.vh as LSOC1K_LD_DEPTH.
- One sub-module, cpu7_byp_mux: a priority forwarding mux for one source index, parametrised by NBYP. It is instantiated twice, once for rs1 and once for rs2.
- The scoreboard and counter live in the top module.

## Test plan
- Reset with no traffic: bypass channels drive rd=3 with values 0xAAAA0001 (channel 0) and 0xBBBB0002 (channel 1). Read rs1=3 -> rs1_fwd_d=0xAAAA0001. Drop channel 0 -> 0xBBBB0002. Read rs2=0 -> 0.
- Accept a load with rd=5. Next cycle issue rs1=5 -> stall_d=1 for 3 cycles. Return ld rd=5, data 0x12345678 -> stall_d=0 in the same cycle, rs1_fwd_d=0x12345678, ld_pend_cnt back to 0.
- WAW: load to rd=7 pending, then an ALU op with rd=7 -> stall_d=1 until ld_ret rd=7.
- Queue full at LD_DEPTH=4: accept loads to r1–r4 -> cnt=4, and a 5th load to r6 stalls. Return r1 in the same cycle as the r6 issue -> r6 is accepted and cnt stays 4.
- ld_ret rd=9 with no load pending -> scb_err=1 sticky and cnt unchanged. Assert reset asynchronously mid-cycle -> scb_err=0, all pend=0 before the next edge.

Source files
------------

// File: rtl/cpu7_exu_byp_scb_pkg.sv
// cpu7_exu_byp_scb_pkg
//   Shared defaults for the execution-unit bypass/scoreboard slice.
//   GRLEN_DEFAULT   : datapath width used by the cpu7 core.
//   LSOC1K_LD_DEPTH : default number of outstanding long-latency loads.
//   LSOC1K_LD_CNT_W : width of a counter able to hold 0..LSOC1K_LD_DEPTH.
//   ld_cnt_w()      : same width rule for an arbitrary depth.
package cpu7_exu_byp_scb_pkg;

  localparam int GRLEN_DEFAULT   = 32;
  localparam int LSOC1K_LD_DEPTH = 4;
  localparam int LSOC1K_LD_CNT_W = $clog2(LSOC1K_LD_DEPTH + 1);

  function automatic int ld_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cpu7_byp_mux.sv
// cpu7_byp_mux
//   Priority forwarding mux for one source register index.
//   Priority, highest first: x0 -> zero, bypass channel 0..NBYP-1
//   (lowest index wins), load-return data, register-file data.
//   Channels or returns that name x0 never match.
// Ports:
//   src_i        source register index
//   irf_data_i   register-file read data for src_i
//   byp_valid_i  per-channel valid
//   byp_rd_i     packed channel destinations, channel i at [i*RW +: RW]
//   byp_data_i   packed channel data, channel i at [i*GRLEN +: GRLEN]
//   ret_hit_i    load return valid with a non-zero destination
//   ret_rd_i     load return destination
//   ret_data_i   load return data
//   fwd_o        forwarded operand
module cpu7_byp_mux #(
  parameter int GRLEN = 32,
  parameter int RW    = 5,
  parameter int NBYP  = 2
) (
  input  logic [RW-1:0]         src_i,
  input  logic [GRLEN-1:0]      irf_data_i,
  input  logic [NBYP-1:0]       byp_valid_i,
  input  logic [NBYP*RW-1:0]    byp_rd_i,
  input  logic [NBYP*GRLEN-1:0] byp_data_i,
  input  logic                  ret_hit_i,
  input  logic [RW-1:0]         ret_rd_i,
  input  logic [GRLEN-1:0]      ret_data_i,
  output logic [GRLEN-1:0]      fwd_o
);

  always_comb begin
    fwd_o = irf_data_i;
    if (ret_hit_i && (ret_rd_i == src_i)) begin
      fwd_o = ret_data_i;
    end
    // Walk from the oldest channel to the youngest so the lowest index
    // is the last assignment and therefore wins.
    for (int i = NBYP - 1; i >= 0; i--) begin
      if (byp_valid_i[i] && (byp_rd_i[i*RW +: RW] == src_i) &&
          (byp_rd_i[i*RW +: RW] != '0)) begin
        fwd_o = byp_data_i[i*GRLEN +: GRLEN];
      end
    end
    if (src_i == '0) begin
      fwd_o = '0;
    end
  end

endmodule

// File: rtl/cpu7_exu_byp_scb.sv
// cpu7_exu_byp_scb
//   Operand bypass plus load scoreboard between D-stage register reads and
//   the E-stage operand latches. Forwards in-flight results, tracks
//   destinations of outstanding long-latency loads and stalls D on RAW,
//   WAW and load-queue-full hazards.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   issue_valid_d              D-stage instruction present
//   rs1_d, rs2_d, rd_d         source / destination indices
//   rd_wen_d, is_load_d        writes rd / long-latency load
//   irf_rs1_data_d, irf_rs2_data_d  register-file read data
//   stall_e                    downstream hold, blocks acceptance only
//   byp_valid, byp_rd, byp_data      packed bypass channels (0 = youngest)
//   ld_ret_valid, ld_ret_rd, ld_ret_data  LSU load return
//   rs1_fwd_d, rs2_fwd_d       forwarded operands (combinational)
//   stall_d                    hazard stall (combinational)
//   ld_pend_cnt                outstanding loads (registered)
//   scb_err                    sticky: load returned to a non-pending reg
// Handshake: an instruction is consumed in a cycle exactly when
//   issue_valid_d & !stall_d & !stall_e; only then does it touch state.
module cpu7_exu_byp_scb
  import cpu7_exu_byp_scb_pkg::*;
#(
  parameter int GRLEN    = GRLEN_DEFAULT,
  parameter int RW       = 5,
  parameter int NBYP     = 2,
  parameter int LD_DEPTH = LSOC1K_LD_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid_d,
  input  logic [RW-1:0]                 rs1_d,
  input  logic [RW-1:0]                 rs2_d,
  input  logic [RW-1:0]                 rd_d,
  input  logic                          rd_wen_d,
  input  logic                          is_load_d,
  input  logic [GRLEN-1:0]              irf_rs1_data_d,
  input  logic [GRLEN-1:0]              irf_rs2_data_d,
  input  logic                          stall_e,
  input  logic [NBYP-1:0]               byp_valid,
  input  logic [NBYP*RW-1:0]            byp_rd,
  input  logic [NBYP*GRLEN-1:0]         byp_data,
  input  logic                          ld_ret_valid,
  input  logic [RW-1:0]                 ld_ret_rd,
  input  logic [GRLEN-1:0]              ld_ret_data,
  output logic [GRLEN-1:0]              rs1_fwd_d,
  output logic [GRLEN-1:0]              rs2_fwd_d,
  output logic                          stall_d,
  output logic [ld_cnt_w(LD_DEPTH)-1:0] ld_pend_cnt,
  output logic                          scb_err
);

  localparam int NREG = 2 ** RW;
  localparam int CW   = ld_cnt_w(LD_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic ret_hit, ret_pend, ret_orphan;
  logic rs1_rdy, rs2_rdy, rd_rdy;
  logic load_trk, ld_full, accept, set_ld;

  // A returning load makes its register ready in the same cycle, so a
  // dependent can issue alongside the return and pick up ld_ret_data.
  assign ret_hit = ld_ret_valid && (ld_ret_rd != '0);
  assign rs1_rdy = (rs1_d == '0) || !pend_q[rs1_d] || (ret_hit && (ld_ret_rd == rs1_d));
  assign rs2_rdy = (rs2_d == '0) || !pend_q[rs2_d] || (ret_hit && (ld_ret_rd == rs2_d));
  assign rd_rdy  = (rd_d  == '0) || !pend_q[rd_d]  || (ret_hit && (ld_ret_rd == rd_d));

  assign load_trk = is_load_d && rd_wen_d && (rd_d != '0);
  assign ld_full  = (cnt_q == DEPTH_C);

  assign stall_d = issue_valid_d &&
                   (!rs1_rdy || !rs2_rdy || (rd_wen_d && !rd_rdy) ||
                    (load_trk && ld_full && !ret_hit));

  assign accept     = issue_valid_d && !stall_d && !stall_e;
  assign set_ld     = accept && load_trk;
  assign ret_pend   = ret_hit && pend_q[ld_ret_rd];
  assign ret_orphan = ret_hit && !pend_q[ld_ret_rd];

  always_comb begin
    pend_d = pend_q;
    if (ret_hit) begin
      pend_d[ld_ret_rd] = 1'b0;
    end
    // Set after clear: a load reissued to the register being returned
    // keeps it pending.
    if (set_ld) begin
      pend_d[rd_d] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({set_ld, ret_pend})
      2'b10:   if (cnt_q != DEPTH_C) cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0)      cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q || ret_orphan;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign ld_pend_cnt = cnt_q;
  assign scb_err     = err_q;

  cpu7_byp_mux #(.GRLEN(GRLEN), .RW(RW), .NBYP(NBYP)) u_rs1_mux (
    .src_i       (rs1_d),
    .irf_data_i  (irf_rs1_data_d),
    .byp_valid_i (byp_valid),
    .byp_rd_i    (byp_rd),
    .byp_data_i  (byp_data),
    .ret_hit_i   (ret_hit),
    .ret_rd_i    (ld_ret_rd),
    .ret_data_i  (ld_ret_data),
    .fwd_o       (rs1_fwd_d)
  );

  cpu7_byp_mux #(.GRLEN(GRLEN), .RW(RW), .NBYP(NBYP)) u_rs2_mux (
    .src_i       (rs2_d),
    .irf_data_i  (irf_rs2_data_d),
    .byp_valid_i (byp_valid),
    .byp_rd_i    (byp_rd),
    .byp_data_i  (byp_data),
    .ret_hit_i   (ret_hit),
    .ret_rd_i    (ld_ret_rd),
    .ret_data_i  (ld_ret_data),
    .fwd_o       (rs2_fwd_d)
  );

endmodule

// File: tb/tb_cpu7_exu_byp_scb.sv
module tb_cpu7_exu_byp_scb;

  localparam int GRLEN = 32;
  localparam int RW    = 5;
  localparam int NBYP  = 2;
  localparam int LD_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic             issue_valid_d, rd_wen_d, is_load_d, stall_e;
  logic [RW-1:0]    rs1_d, rs2_d, rd_d;
  logic [GRLEN-1:0] irf_rs1_data_d, irf_rs2_data_d;
  logic [NBYP-1:0]  byp_valid;
  logic [RW-1:0]    brd [NBYP];
  logic [GRLEN-1:0] bd  [NBYP];
  logic [NBYP*RW-1:0]    byp_rd;
  logic [NBYP*GRLEN-1:0] byp_data;
  logic             ld_ret_valid;
  logic [RW-1:0]    ld_ret_rd;
  logic [GRLEN-1:0] ld_ret_data;
  logic [GRLEN-1:0] rs1_fwd_d, rs2_fwd_d;
  logic             stall_d;
  logic [2:0]       ld_pend_cnt;
  logic             scb_err;

  assign byp_rd   = {brd[1], brd[0]};
  assign byp_data = {bd[1], bd[0]};

  cpu7_exu_byp_scb #(.GRLEN(GRLEN), .RW(RW), .NBYP(NBYP), .LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .issue_valid_d(issue_valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .rd_wen_d(rd_wen_d), .is_load_d(is_load_d),
    .irf_rs1_data_d(irf_rs1_data_d), .irf_rs2_data_d(irf_rs2_data_d),
    .stall_e(stall_e), .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
    .ld_ret_valid(ld_ret_valid), .ld_ret_rd(ld_ret_rd), .ld_ret_data(ld_ret_data),
    .rs1_fwd_d(rs1_fwd_d), .rs2_fwd_d(rs2_fwd_d), .stall_d(stall_d),
    .ld_pend_cnt(ld_pend_cnt), .scb_err(scb_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [GRLEN-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The architectural view: a set of registers awaiting load data, the
  // outstanding count being simply how many are in that set.
  bit pend_m [32];
  bit err_m;

  function automatic int cnt_m();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(pend_m[r]);
    return c;
  endfunction

  function automatic bit ret_hit_m();
    return ld_ret_valid && (ld_ret_rd != 0);
  endfunction

  function automatic bit ready_m(input logic [RW-1:0] r);
    return (r == 0) || !pend_m[r] || (ret_hit_m() && ld_ret_rd == r);
  endfunction

  function automatic logic [GRLEN-1:0] fwd_m(input logic [RW-1:0] s, input logic [GRLEN-1:0] irf);
    if (s == 0) return '0;
    for (int i = 0; i < NBYP; i++)
      if (byp_valid[i] && brd[i] == s && brd[i] != 0) return bd[i];
    if (ret_hit_m() && ld_ret_rd == s) return ld_ret_data;
    return irf;
  endfunction

  function automatic bit stall_m();
    bit raw, waw, full;
    raw  = !ready_m(rs1_d) || !ready_m(rs2_d);
    waw  = rd_wen_d && !ready_m(rd_d);
    full = is_load_d && rd_wen_d && rd_d != 0 && cnt_m() == LD_DEPTH && !ret_hit_m();
    return issue_valid_d && (raw || waw || full);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
    err_m = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    issue_valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0; rd_wen_d = 0; is_load_d = 0;
    stall_e = 0; byp_valid = 0; brd[0] = 0; brd[1] = 0; bd[0] = 0; bd[1] = 0;
    ld_ret_valid = 0; ld_ret_rd = 0; ld_ret_data = 0;
    irf_rs1_data_d = 32'h1111_1111; irf_rs2_data_d = 32'h2222_2222;
  endtask

  task automatic drive_instr(input logic [RW-1:0] r1, input logic [RW-1:0] r2,
                             input logic [RW-1:0] rd, input bit wen, input bit ld);
    issue_valid_d = 1; rs1_d = r1; rs2_d = r2; rd_d = rd; rd_wen_d = wen; is_load_d = ld;
  endtask

  task automatic drive_ret(input logic [RW-1:0] rd, input logic [GRLEN-1:0] data);
    ld_ret_valid = 1; ld_ret_rd = rd; ld_ret_data = data;
  endtask

  // Compare combinational outputs mid-cycle, clock once, advance the
  // model, then compare registered outputs just after the edge.
  task automatic tick_check();
    bit exp_stall, do_set, hit;
    logic [RW-1:0] rrd, drd;
    @(negedge clk);
    exp_stall = stall_m();
    exp_q.push_back(fwd_m(rs1_d, irf_rs1_data_d));
    exp_q.push_back(fwd_m(rs2_d, irf_rs2_data_d));
    exp_q.push_back({31'b0, exp_stall});
    chk("rs1_fwd", rs1_fwd_d, exp_q.pop_front());
    chk("rs2_fwd", rs2_fwd_d, exp_q.pop_front());
    chk("stall_d", {31'b0, stall_d}, exp_q.pop_front());
    do_set = issue_valid_d && !exp_stall && !stall_e && is_load_d && rd_wen_d && rd_d != 0;
    hit = ret_hit_m();
    rrd = ld_ret_rd;
    drd = rd_d;
    @(posedge clk);
    if (hit) begin
      if (pend_m[rrd]) pend_m[rrd] = 1'b0;
      else             err_m = 1'b1;
    end
    if (do_set) pend_m[drd] = 1'b1;
    #1;
    chk("ld_pend_cnt", {29'b0, ld_pend_cnt}, cnt_m());
    chk("scb_err", {31'b0, scb_err}, {31'b0, err_m});
  endtask

  // ---------------- forwarding vector table ----------------
  typedef struct {
    logic [RW-1:0]    rs1, rs2;
    logic [1:0]       bv;
    logic [RW-1:0]    r0, r1;
    logic [GRLEN-1:0] d0, d1;
    logic             rv;
    logic [RW-1:0]    rr;
    logic [GRLEN-1:0] rdat, e1, e2;
  } vec_t;
  vec_t vecs [8];

  localparam logic [31:0] A  = 32'hAAAA_0001;
  localparam logic [31:0] B  = 32'hBBBB_0002;
  localparam logic [31:0] C  = 32'hCAFE_0000;
  localparam logic [31:0] I1 = 32'h1111_1111;
  localparam logic [31:0] I2 = 32'h2222_2222;

  initial begin
    int q[$];
    reset = 1'b1;
    drive_idle();
    model_reset();

    vecs[0] = '{5'd3, 5'd0, 2'b11, 5'd3, 5'd3, A, B, 1'b0, 5'd0, 32'h0, A,  32'h0};
    vecs[1] = '{5'd3, 5'd0, 2'b10, 5'd3, 5'd3, A, B, 1'b0, 5'd0, 32'h0, B,  32'h0};
    vecs[2] = '{5'd3, 5'd4, 2'b00, 5'd3, 5'd3, A, B, 1'b0, 5'd0, 32'h0, I1, I2};
    vecs[3] = '{5'd0, 5'd4, 2'b11, 5'd0, 5'd4, A, B, 1'b0, 5'd0, 32'h0, 32'h0, B};
    vecs[4] = '{5'd6, 5'd2, 2'b01, 5'd6, 5'd2, A, B, 1'b1, 5'd6, C,     A,  I2};
    vecs[5] = '{5'd6, 5'd6, 2'b00, 5'd6, 5'd2, A, B, 1'b1, 5'd6, C,     C,  C};
    vecs[6] = '{5'd0, 5'd5, 2'b00, 5'd0, 5'd0, A, B, 1'b1, 5'd0, 32'hDEAD_0000, 32'h0, I2};
    vecs[7] = '{5'd9, 5'd5, 2'b11, 5'd5, 5'd9, A, B, 1'b1, 5'd9, C,     B,  A};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_cnt", {29'b0, ld_pend_cnt}, 32'd0);
    chk("reset_err", {31'b0, scb_err}, 32'd0);

    // Table: pure combinational forwarding, held in reset so no state moves.
    for (int k = 0; k < 8; k++) begin
      rs1_d = vecs[k].rs1; rs2_d = vecs[k].rs2; byp_valid = vecs[k].bv;
      brd[0] = vecs[k].r0; brd[1] = vecs[k].r1; bd[0] = vecs[k].d0; bd[1] = vecs[k].d1;
      ld_ret_valid = vecs[k].rv; ld_ret_rd = vecs[k].rr; ld_ret_data = vecs[k].rdat;
      #1;
      chk($sformatf("vec%0d_rs1", k), rs1_fwd_d, vecs[k].e1);
      chk($sformatf("vec%0d_rs2", k), rs2_fwd_d, vecs[k].e2);
      chk($sformatf("vec%0d_stall", k), {31'b0, stall_d}, 32'd0);
    end
    drive_idle();
    @(posedge clk); #1;
    reset = 1'b0;

    // Load-use: load r5, dependent stalls 3 cycles, issues on the return.
    drive_instr(0, 0, 5, 1, 1); #1;
    chk("A_load_stall", {31'b0, stall_d}, 32'd0);
    tick_check();
    chk("A_cnt1", {29'b0, ld_pend_cnt}, 32'd1);
    drive_idle(); drive_instr(5, 0, 10, 1, 0); #1;
    for (int c = 0; c < 3; c++) begin
      chk("A_raw_stall", {31'b0, stall_d}, 32'd1);
      tick_check();
    end
    drive_ret(5, 32'h1234_5678); #1;
    chk("A_ret_stall", {31'b0, stall_d}, 32'd0);
    chk("A_ret_fwd", rs1_fwd_d, 32'h1234_5678);
    tick_check();
    chk("A_cnt0", {29'b0, ld_pend_cnt}, 32'd0);

    // WAW: ALU write to a register with a load in flight.
    drive_idle(); drive_instr(0, 0, 7, 1, 1); tick_check();
    drive_idle(); drive_instr(1, 2, 7, 1, 0); #1;
    for (int c = 0; c < 2; c++) begin
      chk("B_waw_stall", {31'b0, stall_d}, 32'd1);
      tick_check();
    end
    drive_ret(7, 32'h0000_0777); #1;
    chk("B_waw_release", {31'b0, stall_d}, 32'd0);
    tick_check();

    // Queue full: four loads outstanding, fifth stalls until a return.
    for (int r = 1; r <= 4; r++) begin
      drive_idle(); drive_instr(0, 0, r[RW-1:0], 1, 1); tick_check();
    end
    chk("C_cnt_full", {29'b0, ld_pend_cnt}, 32'd4);
    drive_idle(); drive_instr(0, 0, 6, 1, 1); #1;
    chk("C_full_stall", {31'b0, stall_d}, 32'd1);
    tick_check();
    drive_ret(1, 32'h0000_0001); #1;
    chk("C_full_ret_accept", {31'b0, stall_d}, 32'd0);
    tick_check();
    chk("C_cnt_stays", {29'b0, ld_pend_cnt}, 32'd4);
    drive_idle(); drive_instr(1, 0, 0, 0, 0); #1;
    chk("C_r1_free", {31'b0, stall_d}, 32'd0);
    tick_check();
    drive_idle(); drive_instr(2, 0, 0, 0, 0); #1;
    chk("C_r2_busy", {31'b0, stall_d}, 32'd1);
    tick_check();

    // Orphan return, sticky error, asynchronous reset mid-cycle.
    drive_idle(); drive_ret(9, 32'h9999_9999); tick_check();
    chk("D_err", {31'b0, scb_err}, 32'd1);
    chk("D_cnt_same", {29'b0, ld_pend_cnt}, 32'd4);
    drive_idle(); tick_check();
    chk("D_err_sticky", {31'b0, scb_err}, 32'd1);
    drive_instr(2, 0, 0, 0, 0); #1;
    chk("D_pre_reset_stall", {31'b0, stall_d}, 32'd1);
    reset = 1'b1; #1;
    model_reset();
    chk("D_rst_err", {31'b0, scb_err}, 32'd0);
    chk("D_rst_cnt", {29'b0, ld_pend_cnt}, 32'd0);
    chk("D_rst_pend", {31'b0, stall_d}, 32'd0);
    #1 reset = 1'b0;
    drive_idle(); drive_ret(3, 32'h3333_3333); tick_check();
    chk("D_post_rst_err", {31'b0, scb_err}, 32'd1);

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive_idle();
      issue_valid_d = ($urandom_range(0, 3) != 0);
      rs1_d = 5'($urandom_range(0, 7));
      rs2_d = 5'($urandom_range(0, 7));
      rd_d  = 5'($urandom_range(0, 7));
      rd_wen_d  = ($urandom_range(0, 3) != 0);
      is_load_d = ($urandom_range(0, 1) == 1);
      stall_e   = ($urandom_range(0, 4) == 0);
      irf_rs1_data_d = $urandom(); irf_rs2_data_d = $urandom();
      for (int i = 0; i < NBYP; i++) begin
        byp_valid[i] = ($urandom_range(0, 1) == 1);
        brd[i] = 5'($urandom_range(0, 7));
        bd[i]  = $urandom();
      end
      q.delete();
      for (int r = 1; r < 32; r++) if (pend_m[r]) q.push_back(r);
      if (q.size() > 0 && $urandom_range(0, 9) < 4)
        drive_ret(5'(q[$urandom_range(0, q.size() - 1)]), $urandom());
      else if (cnt_m() < LD_DEPTH && $urandom_range(0, 19) == 0)
        drive_ret(5'($urandom_range(0, 7)), $urandom());
      tick_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
